stream_mux_demux_n: RTL and testbench
=====================================

Name: stream_mux_demux_n

Overview:
- Parametrised, registered successor to the team's fixed-width combinational mux/demux.
- Mux path: selects one of CH valid/ready input streams onto one registered output stream.
- Demux path: routes one valid/ready input stream to one of CH registered output streams.
- Sits between datapath sources/sinks and the bus fabric; one pipeline stage per path, full throughput.

Parameters:
- DW, 8, data width per stream.
- CH, 4, number of channels (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= CH.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mux_sel  in  SEL_W  mux channel select (ignored when MUX_RR_EN is defined).
- mux_in_valid  in  CH  per-channel input valid.
- mux_in_data  in  CH*DW  packed input data; channel i at [i*DW +: DW].
- mux_in_ready  out  CH  per-channel input ready.
- mux_out_valid  out  1  registered output valid.
- mux_out_data  out  DW  registered output data.
- mux_out_ch  out  SEL_W  channel index the held word came from.
- mux_out_ready  in  1  downstream ready.
- demux_sel  in  SEL_W  destination channel, sampled with demux_in_valid.
- demux_in_valid  in  1  input valid.
- demux_in_data  in  DW  input data.
- demux_in_ready  out  1  input ready.
- demux_out_valid  out  CH  per-channel output valid; at most one bit set.
- demux_out_data  out  DW  registered data, shared by all channels.
- demux_out_ready  in  CH  per-channel downstream ready.
- demux_err_cnt  out  8  count of words dropped for out-of-range demux_sel; saturates at 255.

Behaviour:
- Reset (async assert, sync release): mux_out_valid=0, mux_out_data=0, mux_out_ch=0, demux_out_valid=0, demux_out_data=0, demux_err_cnt=0, RR pointer=0.
- Handshake rules, all interfaces:
  - Transfer occurs when valid && ready at a rising edge.
  - Valid never depends combinationally on ready.
  - Data and valid hold stable while valid && !ready.
- Mux path:
  - ld = !mux_out_valid || mux_out_ready.
  - sel_eff = mux_sel, or the RR grant when MUX_RR_EN is defined.
  - mux_in_ready[i] = ld && (i == sel_eff) && (sel_eff < CH). All other ready bits are 0.
  - On ld: if mux_in_valid[sel_eff] is 1, register data and channel index and set mux_out_valid=1; otherwise clear mux_out_valid.
  - Latency 1 cycle. Throughput 1 word/cycle under continuous ready.
  - mux_sel >= CH: no input is readied; the output register drains and then goes invalid.
  - mux_sel may change on any cycle; it takes effect on the next ld.
- Demux path:
  - Holding register: data, dest channel (dch), pend flag.
  - demux_out_valid[i] = pend && (dch == i).
  - demux_in_ready = !pend || demux_out_ready[dch].
  - On input transfer with demux_sel < CH: load data and dch, set pend=1.
  - On input transfer with demux_sel >= CH: word accepted and dropped, demux_err_cnt increments (saturating), pend cleared if the held word left that cycle.
  - If the held word leaves and there is no new input transfer, pend=0.
  - Simultaneous drain and load in the same cycle is allowed (full throughput).
  - Latency 1 cycle.
- Reset mid-transfer discards held words; no partial output is produced after rst_n deasserts.
- The two paths are fully independent: no shared state, no cross-path ordering.

Optional Feature:
- Macro: MUX_RR_EN.
- Defined:
  - mux_sel is ignored; sel_eff is a round-robin grant.
  - Grant goes to the first i with mux_in_valid[i]=1, scanning from ptr upward and wrapping at CH.
  - On each mux input transfer, ptr <= (grant+1) mod CH. Without a transfer, ptr holds.
  - With no valid inputs, no channel is readied.
  - Fairness: any continuously-valid channel is served within CH transfers.
- Undefined: no RR pointer logic is present; selection is purely mux_sel.

Test Plan:
- Reset: hold rst_n=0 mid-stream with data in both holding registers -> all outputs 0 immediately (asynchronously); after release, demux_out_valid=0 and mux_out_valid=0 until new input.
- Mux fixed select: mux_sel=2, all four channels valid with data 0xA0..0xA3, mux_out_ready=1 -> one cycle later mux_out_data=0xA2, mux_out_ch=2; mux_in_ready=4'b0100 every cycle.
- Mux backpressure: mux_out_ready=0 for 3 cycles with word 0x55 held -> mux_out_data stays 0x55, mux_in_ready=0; ready=1 -> next word taken with no loss or duplicate.
- Demux routing: send 0x11 (sel 0), 0x22 (sel 3), 0x33 (sel 1) back-to-back, all outputs ready -> demux_out_valid = 0001, 1000, 0010 on consecutive cycles with matching data.
- Demux error and stall:
  - demux_sel=5 with CH=4 -> word dropped, demux_err_cnt=1, no output valid.
  - demux_out_ready[3]=0 with a word pending to ch3 -> demux_in_ready=0 until ready[3]=1.
  - 300 bad words -> demux_err_cnt=255.
- MUX_RR_EN: all channels continuously valid, ready=1 -> mux_out_ch sequence 0,1,2,3,0.
  - Only ch1 and ch3 valid -> sequence 1,3,1,3.

Source files
------------

// File: rtl/stream_mux_demux_n_if.sv
// Handshake bundle for stream_mux_demux_n: a CH:1 mux path and a 1:CH demux path.
// The master drives the inputs and the slave is the mux/demux block itself.
interface stream_mux_demux_n_if #(
  parameter int DW    = 8,
  parameter int CH    = 4,
  parameter int SEL_W = 2
);
  logic [SEL_W-1:0]   mux_sel;
  logic [CH-1:0]      mux_in_valid;
  logic [CH*DW-1:0]   mux_in_data;
  logic [CH-1:0]      mux_in_ready;
  logic               mux_out_valid;
  logic [DW-1:0]      mux_out_data;
  logic [SEL_W-1:0]   mux_out_ch;
  logic               mux_out_ready;

  logic [SEL_W-1:0]   demux_sel;
  logic               demux_in_valid;
  logic [DW-1:0]      demux_in_data;
  logic               demux_in_ready;
  logic [CH-1:0]      demux_out_valid;
  logic [DW-1:0]      demux_out_data;
  logic [CH-1:0]      demux_out_ready;
  logic [7:0]         demux_err_cnt;

  modport master (
    output mux_sel, mux_in_valid, mux_in_data, mux_out_ready,
           demux_sel, demux_in_valid, demux_in_data, demux_out_ready,
    input  mux_in_ready, mux_out_valid, mux_out_data, mux_out_ch,
           demux_in_ready, demux_out_valid, demux_out_data, demux_err_cnt
  );

  modport slave (
    input  mux_sel, mux_in_valid, mux_in_data, mux_out_ready,
           demux_sel, demux_in_valid, demux_in_data, demux_out_ready,
    output mux_in_ready, mux_out_valid, mux_out_data, mux_out_ch,
           demux_in_ready, demux_out_valid, demux_out_data, demux_err_cnt
  );
endinterface

// File: rtl/stream_mux_demux_n.sv
// Registered CH:1 stream mux and 1:CH stream demux, one stage each, full throughput.
// Define MUX_RR_EN to replace mux_sel with a round-robin grant on the mux path.
module stream_mux_demux_n #(
  parameter int DW    = 8,
  parameter int CH    = 4,
  parameter int SEL_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  stream_mux_demux_n_if.slave bus
);

  // ---------------- mux path ----------------
  logic [CH-1:0][DW-1:0] mux_d;
  logic [SEL_W-1:0]      sel_eff;
  logic                  sel_ok;
  logic                  sel_vld;
  logic [DW-1:0]         sel_data;
  logic [CH-1:0]         mux_rdy;
  logic                  mux_v_q;
  logic [DW-1:0]         mux_d_q;
  logic [SEL_W-1:0]      mux_ch_q;
  logic                  ld;

  assign mux_d = bus.mux_in_data;
  assign ld    = !mux_v_q || bus.mux_out_ready;

`ifdef MUX_RR_EN
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_gnt;
  logic             rr_any;
  int               rr_j;

  // Descending scan so the lowest offset from rr_ptr wins.
  always_comb begin
    rr_gnt = '0;
    rr_any = 1'b0;
    rr_j   = 0;
    for (int k = CH - 1; k >= 0; k--) begin
      rr_j = int'(rr_ptr) + k;
      if (rr_j >= CH) rr_j = rr_j - CH;
      if (bus.mux_in_valid[rr_j]) begin
        rr_gnt = SEL_W'(rr_j);
        rr_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (ld && rr_any)
      rr_ptr <= (rr_gnt == SEL_W'(CH - 1)) ? '0 : rr_gnt + SEL_W'(1);
  end

  assign sel_eff = rr_gnt;
`else
  assign sel_eff = bus.mux_sel;
`endif

  // Decode by compare rather than index so out-of-range selects read nothing.
  always_comb begin
    sel_ok   = 1'b0;
    sel_vld  = 1'b0;
    sel_data = '0;
    mux_rdy  = '0;
    for (int i = 0; i < CH; i++) begin
      if (sel_eff == SEL_W'(i)) begin
        sel_ok   = 1'b1;
        sel_vld  = bus.mux_in_valid[i];
        sel_data = mux_d[i];
      end
    end
`ifdef MUX_RR_EN
    sel_ok = sel_ok && rr_any;
`endif
    for (int i = 0; i < CH; i++)
      mux_rdy[i] = ld && sel_ok && (sel_eff == SEL_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_v_q  <= 1'b0;
      mux_d_q  <= '0;
      mux_ch_q <= '0;
    end else if (ld) begin
      if (sel_ok && sel_vld) begin
        mux_v_q  <= 1'b1;
        mux_d_q  <= sel_data;
        mux_ch_q <= sel_eff;
      end else begin
        mux_v_q  <= 1'b0;
      end
    end
  end

  assign bus.mux_in_ready  = mux_rdy;
  assign bus.mux_out_valid = mux_v_q;
  assign bus.mux_out_data  = mux_d_q;
  assign bus.mux_out_ch    = mux_ch_q;

  // ---------------- demux path ----------------
  logic             pend;
  logic [SEL_W-1:0] dch;
  logic [DW-1:0]    dem_d_q;
  logic [7:0]       err_cnt;
  logic             dst_rdy;
  logic             dsel_ok;
  logic             drain;
  logic             in_rdy;
  logic             in_xfer;
  logic [CH-1:0]    dem_vld;

  always_comb begin
    dst_rdy = 1'b0;
    dsel_ok = 1'b0;
    dem_vld = '0;
    for (int i = 0; i < CH; i++) begin
      if (dch == SEL_W'(i)) dst_rdy = bus.demux_out_ready[i];
      if (bus.demux_sel == SEL_W'(i)) dsel_ok = 1'b1;
      dem_vld[i] = pend && (dch == SEL_W'(i));
    end
  end

  assign drain   = pend && dst_rdy;
  assign in_rdy  = !pend || dst_rdy;
  assign in_xfer = bus.demux_in_valid && in_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend    <= 1'b0;
      dch     <= '0;
      dem_d_q <= '0;
      err_cnt <= '0;
    end else begin
      if (in_xfer && dsel_ok) begin
        pend    <= 1'b1;
        dch     <= bus.demux_sel;
        dem_d_q <= bus.demux_in_data;
      end else begin
        pend <= pend && !drain;
      end
      // Misrouted words are swallowed; only the count records them.
      if (in_xfer && !dsel_ok && (err_cnt != 8'hFF))
        err_cnt <= err_cnt + 8'd1;
    end
  end

  assign bus.demux_in_ready  = in_rdy;
  assign bus.demux_out_valid = dem_vld;
  assign bus.demux_out_data  = dem_d_q;
  assign bus.demux_err_cnt   = err_cnt;

endmodule

// File: tb/tb_stream_mux_demux_n.sv
// Directed bench for stream_mux_demux_n (CH=4, SEL_W=3 so out-of-range selects are reachable).
module tb_stream_mux_demux_n;
  localparam int DW = 8, CH = 4, SEL_W = 3;

  logic clk;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  stream_mux_demux_n_if #(.DW(DW), .CH(CH), .SEL_W(SEL_W)) bus ();

  stream_mux_demux_n #(.DW(DW), .CH(CH), .SEL_W(SEL_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst_n                 = 1'b0;
    bus.mux_sel           = '0;
    bus.mux_in_valid      = '0;
    bus.mux_in_data       = '0;
    bus.mux_out_ready     = 1'b0;
    bus.demux_sel         = '0;
    bus.demux_in_valid    = 1'b0;
    bus.demux_in_data     = '0;
    bus.demux_out_ready   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mux_valid", 32'(bus.mux_out_valid), 32'd0);
    chk("rst_mux_data", 32'(bus.mux_out_data), 32'd0);
    chk("rst_mux_ch", 32'(bus.mux_out_ch), 32'd0);
    chk("rst_dmx_valid", 32'(bus.demux_out_valid), 32'd0);
    chk("rst_dmx_data", 32'(bus.demux_out_data), 32'd0);
    chk("rst_err_cnt", 32'(bus.demux_err_cnt), 32'd0);
    rst_n = 1'b1;

`ifdef MUX_RR_EN
    // Round robin, all channels valid: 0,1,2,3,0
    bus.mux_in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.mux_in_valid  = 4'hF;
    bus.mux_out_ready = 1'b1;
    settle();
    chk("rr_rdy_first", 32'(bus.mux_in_ready), 32'h1);
    begin
      int exp_all [5] = '{0, 1, 2, 3, 0};
      for (int k = 0; k < 5; k++) begin
        step();
        chk($sformatf("rr_all_ch%0d", k), 32'(bus.mux_out_ch), 32'(exp_all[k]));
        chk($sformatf("rr_all_dat%0d", k), 32'(bus.mux_out_data), 32'hA0 + 32'(exp_all[k]));
      end
    end
    // Only ch1/ch3 valid, pointer now at 1: 1,3,1,3
    bus.mux_in_valid = 4'b1010;
    begin
      int exp_odd [4] = '{1, 3, 1, 3};
      for (int k = 0; k < 4; k++) begin
        step();
        chk($sformatf("rr_odd_ch%0d", k), 32'(bus.mux_out_ch), 32'(exp_odd[k]));
      end
    end
    bus.mux_in_valid = '0;
    settle();
    chk("rr_none_rdy", 32'(bus.mux_in_ready), 32'd0);
    step();
    chk("rr_none_valid", 32'(bus.mux_out_valid), 32'd0);
`else
    // Fixed select on channel 2
    bus.mux_sel       = 3'd2;
    bus.mux_in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.mux_in_valid  = 4'hF;
    bus.mux_out_ready = 1'b1;
    settle();
    chk("mux_rdy_pre", 32'(bus.mux_in_ready), 32'b0100);
    step();
    chk("mux_fix_valid", 32'(bus.mux_out_valid), 32'd1);
    chk("mux_fix_data", 32'(bus.mux_out_data), 32'hA2);
    chk("mux_fix_ch", 32'(bus.mux_out_ch), 32'd2);
    chk("mux_fix_rdy", 32'(bus.mux_in_ready), 32'b0100);

    // Backpressure with 0x55 held
    bus.mux_in_data[23:16] = 8'h55;
    step();
    chk("mux_bp_load", 32'(bus.mux_out_data), 32'h55);
    bus.mux_out_ready      = 1'b0;
    bus.mux_in_data[23:16] = 8'h66;
    settle();
    chk("mux_bp_rdy0", 32'(bus.mux_in_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("mux_bp_hold%0d", k), 32'(bus.mux_out_data), 32'h55);
      chk($sformatf("mux_bp_vld%0d", k), 32'(bus.mux_out_valid), 32'd1);
      chk($sformatf("mux_bp_rdy%0d", k), 32'(bus.mux_in_ready), 32'd0);
    end
    bus.mux_out_ready = 1'b1;
    settle();
    chk("mux_bp_rel_rdy", 32'(bus.mux_in_ready), 32'b0100);
    step();
    chk("mux_bp_next", 32'(bus.mux_out_data), 32'h66);
    chk("mux_bp_next_v", 32'(bus.mux_out_valid), 32'd1);
    bus.mux_in_valid = '0;
    step();
    chk("mux_bp_nodup", 32'(bus.mux_out_valid), 32'd0);

    // Out-of-range select readies nothing and leaves the output invalid
    bus.mux_in_valid = 4'hF;
    bus.mux_sel      = 3'd4;
    settle();
    chk("mux_oor_rdy", 32'(bus.mux_in_ready), 32'd0);
    step();
    chk("mux_oor_valid", 32'(bus.mux_out_valid), 32'd0);
    bus.mux_in_valid = '0;
`endif

    // Demux routing 0x11->0, 0x22->3, 0x33->1
    bus.demux_out_ready = 4'hF;
    bus.demux_in_valid  = 1'b1;
    bus.demux_sel       = 3'd0;
    bus.demux_in_data   = 8'h11;
    settle();
    chk("dmx_in_rdy", 32'(bus.demux_in_ready), 32'd1);
    step();
    chk("dmx_v0", 32'(bus.demux_out_valid), 32'b0001);
    chk("dmx_d0", 32'(bus.demux_out_data), 32'h11);
    bus.demux_sel     = 3'd3;
    bus.demux_in_data = 8'h22;
    step();
    chk("dmx_v1", 32'(bus.demux_out_valid), 32'b1000);
    chk("dmx_d1", 32'(bus.demux_out_data), 32'h22);
    bus.demux_sel     = 3'd1;
    bus.demux_in_data = 8'h33;
    step();
    chk("dmx_v2", 32'(bus.demux_out_valid), 32'b0010);
    chk("dmx_d2", 32'(bus.demux_out_data), 32'h33);
    bus.demux_in_valid = 1'b0;
    step();
    chk("dmx_drained", 32'(bus.demux_out_valid), 32'd0);

    // Out-of-range destination is dropped and counted
    bus.demux_in_valid = 1'b1;
    bus.demux_sel      = 3'd5;
    bus.demux_in_data  = 8'hEE;
    step();
    bus.demux_in_valid = 1'b0;
    chk("dmx_err1", 32'(bus.demux_err_cnt), 32'd1);
    chk("dmx_err_novld", 32'(bus.demux_out_valid), 32'd0);

    // Stall on ch3
    bus.demux_out_ready = 4'b0111;
    bus.demux_in_valid  = 1'b1;
    bus.demux_sel       = 3'd3;
    bus.demux_in_data   = 8'h44;
    step();
    chk("dmx_st_v", 32'(bus.demux_out_valid), 32'b1000);
    chk("dmx_st_d", 32'(bus.demux_out_data), 32'h44);
    bus.demux_sel     = 3'd0;
    bus.demux_in_data = 8'h77;
    settle();
    chk("dmx_st_rdy0", 32'(bus.demux_in_ready), 32'd0);
    step();
    chk("dmx_st_hold", 32'(bus.demux_out_data), 32'h44);
    chk("dmx_st_rdy1", 32'(bus.demux_in_ready), 32'd0);
    bus.demux_out_ready = 4'hF;
    settle();
    chk("dmx_st_rel", 32'(bus.demux_in_ready), 32'd1);
    step();
    chk("dmx_st_nv", 32'(bus.demux_out_valid), 32'b0001);
    chk("dmx_st_nd", 32'(bus.demux_out_data), 32'h77);
    bus.demux_in_valid = 1'b0;
    step();
    chk("dmx_st_empty", 32'(bus.demux_out_valid), 32'd0);

    // 300 bad words saturate the counter
    bus.demux_in_valid = 1'b1;
    bus.demux_sel      = 3'd6;
    repeat (300) step();
    bus.demux_in_valid = 1'b0;
    chk("dmx_err_sat", 32'(bus.demux_err_cnt), 32'd255);

    // Async reset with both holding registers loaded
    bus.mux_sel         = 3'd1;
    bus.mux_in_data     = {8'hB3, 8'hB2, 8'hB1, 8'hB0};
    bus.mux_in_valid    = 4'hF;
    bus.mux_out_ready   = 1'b0;
    bus.demux_out_ready = 4'b0000;
    bus.demux_in_valid  = 1'b1;
    bus.demux_sel       = 3'd2;
    bus.demux_in_data   = 8'h99;
    step();
    chk("mid_mux_v", 32'(bus.mux_out_valid), 32'd1);
    chk("mid_dmx_v", 32'(bus.demux_out_valid), 32'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_mux_v", 32'(bus.mux_out_valid), 32'd0);
    chk("ar_mux_d", 32'(bus.mux_out_data), 32'd0);
    chk("ar_mux_ch", 32'(bus.mux_out_ch), 32'd0);
    chk("ar_dmx_v", 32'(bus.demux_out_valid), 32'd0);
    chk("ar_dmx_d", 32'(bus.demux_out_data), 32'd0);
    chk("ar_err", 32'(bus.demux_err_cnt), 32'd0);
    bus.mux_in_valid   = '0;
    bus.demux_in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("post_mux_v", 32'(bus.mux_out_valid), 32'd0);
    chk("post_dmx_v", 32'(bus.demux_out_valid), 32'd0);
    step();
    chk("post_mux_v2", 32'(bus.mux_out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
